mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single-port data memory between instruction fetch (IF) and the load/store path (D, driven by controller mem_read/mem_write/mask).
//  One outstanding memory transaction at a time; D has priority, with a starvation guard that forces an IF grant.
//  Per-access timeout with a sticky error flag. Honours controller is_halted: no new grants.
// PARAMETERS
//  N             32  data/mask width
//  M             16  address width
//  STARVE_LIMIT  4   consecutive D grants while IF pending before IF is forced (>=1)
//  TIMEOUT       16  max cycles from mem_ack to mem_done before abort (>=2)
// PORTS
//  clk        in   1  clock, rising edge
//  rst_n      in   1  asynchronous active-low reset
//  halted     in   1  from controller is_halted; blocks new grants
//  if_req     in   1  fetch request, held until if_gnt
//  if_addr    in   M  fetch address
//  if_gnt     out  1  1-cycle pulse: fetch captured
//  if_rvalid  out  1  1-cycle pulse: fetch complete
//  if_rdata   out  N  fetch data, valid with if_rvalid
//  d_req      in   1  load/store request, held until d_gnt
//  d_we       in   1  1 = store, 0 = load
//  d_addr     in   M  data address (ALU result)
//  d_wdata    in   N  store data
//  d_mask     in   N  byte/half/word mask from controller
//  d_gnt      out  1  1-cycle pulse: data request captured
//  d_done     out  1  1-cycle pulse: load/store complete
//  d_rdata    out  N  load data (masked), valid with d_done
//  mem_req    out  1  memory request, held until mem_ack
//  mem_we     out  1  memory write enable
//  mem_addr   out  M  memory address
//  mem_wdata  out  N  memory write data
//  mem_mask   out  N  memory write mask (all ones for fetch)
//  mem_ack    in   1  memory accepted request
//  mem_done   in   1  memory completed access; never in the same cycle as mem_ack
//  mem_rdata  in   N  memory read data, valid with mem_done
//  bus_err    out  1  sticky timeout flag; cleared only by reset
// BEHAVIOUR
//  Reset (async, rst_n=0): state IDLE, every output 0, starve_cnt=0, timeout counter 0. No completion pulse is issued for an in-flight access killed by reset.
//  FSM IDLE -> REQ -> WAIT -> IDLE. All outputs are registered.
//  IDLE, halted=0: winner = IF if (if_req && (!d_req || starve_cnt==STARVE_LIMIT)); else D if d_req. On the winning edge: capture addr/we/wdata/mask (IF: we=0, mask all ones), pulse that gnt, go to REQ. No winner or halted=1: stay in IDLE.
//  starve_cnt: on a D grant with if_req=1, increment (saturating at STARVE_LIMIT); on a D grant with if_req=0, or on any IF grant, set to 0.
//  REQ: mem_req=1 with captured fields stable. On mem_ack: mem_req<=0, timeout counter <=0, go to WAIT.
//  WAIT: counter increments each cycle. On mem_done: owner pulse (if_rvalid or d_done) next cycle, go to IDLE.
//    Fetch data = mem_rdata. Load data = mem_rdata & mask. Stores give d_rdata=0.
//  Timeout: counter reaches TIMEOUT-1 with no mem_done -> bus_err<=1, owner pulse with rdata=0, go to IDLE. A late mem_done is ignored.
//  The cycle a completion pulse is high is already IDLE, so a new grant may occur in that cycle: back-to-back grant spacing is 4 cycles minimum.
//  halted rising mid-transaction: the in-flight access completes normally, then no further grants.
//  mem_done outside WAIT is ignored.
//  Only one of if_gnt/d_gnt is high per cycle. Only one of if_rvalid/d_done is high per cycle.
// TESTING
//  IF only, addr 0x0010, mem_ack in first REQ cycle, mem_done 2 cycles later with rdata 0xDEADBEEF -> if_gnt@t, mem_req@t+1, if_rvalid with if_rdata=0xDEADBEEF the cycle after mem_done.
//  if_req and d_req both high at t -> d_gnt@t; if_gnt on the first IDLE cycle after d_done.
//  STARVE_LIMIT=4, d_req and if_req held high continuously -> grant order D,D,D,D,IF,D,D,D,D,IF.
//  Load with mask 0x000000FF, mem_rdata 0x12345678 -> d_rdata=0x00000078. Store of 0xCAFEF00D -> mem_we=1, mem_wdata=0xCAFEF00D, mem_mask=d_mask.
//  TIMEOUT=8, mem_ack then no mem_done -> d_done with d_rdata=0, bus_err=1 held high; next request is served normally.
//  rst_n low during WAIT -> outputs 0 immediately, no d_done after release. halted=1 with d_req held -> no d_gnt.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the single-port data memory between fetch and load/store.
// D-first arbitration with a starvation guard, per-access timeout and sticky bus_err.
module mem_port_arbiter #(
  parameter int N            = 32,
  parameter int M            = 16,
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         halted,
  input  logic         if_req,
  input  logic [M-1:0] if_addr,
  output logic         if_gnt,
  output logic         if_rvalid,
  output logic [N-1:0] if_rdata,
  input  logic         d_req,
  input  logic         d_we,
  input  logic [M-1:0] d_addr,
  input  logic [N-1:0] d_wdata,
  input  logic [N-1:0] d_mask,
  output logic         d_gnt,
  output logic         d_done,
  output logic [N-1:0] d_rdata,
  output logic         mem_req,
  output logic         mem_we,
  output logic [M-1:0] mem_addr,
  output logic [N-1:0] mem_wdata,
  output logic [N-1:0] mem_mask,
  input  logic         mem_ack,
  input  logic         mem_done,
  input  logic [N-1:0] mem_rdata,
  output logic         bus_err
);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [SW-1:0] SMAX  = SW'(STARVE_LIMIT);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t r_state, w_state;

  logic [SW-1:0] r_starve, w_starve;
  logic [TW-1:0] r_tcnt, w_tcnt;
  logic          r_own_d, w_own_d;
  logic          r_if_gnt, w_if_gnt;
  logic          r_d_gnt, w_d_gnt;
  logic          r_if_rvalid, w_if_rvalid;
  logic          r_d_done, w_d_done;
  logic [N-1:0]  r_if_rdata, w_if_rdata;
  logic [N-1:0]  r_d_rdata, w_d_rdata;
  logic          r_mem_req, w_mem_req;
  logic          r_mem_we, w_mem_we;
  logic [M-1:0]  r_mem_addr, w_mem_addr;
  logic [N-1:0]  r_mem_wdata, w_mem_wdata;
  logic [N-1:0]  r_mem_mask, w_mem_mask;
  logic          r_bus_err, w_bus_err;

  logic          w_if_win;
  logic          w_d_win;
  logic          w_grant;
  logic          w_finish;
  logic [N-1:0]  w_rd;

  assign w_if_win = if_req && (!d_req || r_starve == SMAX);
  assign w_d_win  = d_req && !w_if_win;
  assign w_grant  = (r_state == S_IDLE) && !halted
                    && (w_if_win || w_d_win);
  assign w_finish = (r_state == S_WAIT)
                    && (mem_done || r_tcnt == TLAST);
  // Fetch mask is all ones, so one expression covers fetch and load.
  assign w_rd = (mem_done && !r_mem_we) ? (mem_rdata & r_mem_mask) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state;
  end

  always_comb begin
    w_state = r_state;
    unique case (r_state)
      S_IDLE:  if (w_grant) w_state = S_REQ;
      S_REQ:   if (r_mem_req && mem_ack) w_state = S_WAIT;
      S_WAIT:  if (w_finish) w_state = S_IDLE;
      default: w_state = S_IDLE;
    endcase
  end

  always_comb begin
    w_starve    = r_starve;
    w_tcnt      = r_tcnt;
    w_own_d     = r_own_d;
    w_if_gnt    = 1'b0;
    w_d_gnt     = 1'b0;
    w_if_rvalid = 1'b0;
    w_d_done    = 1'b0;
    w_if_rdata  = r_if_rdata;
    w_d_rdata   = r_d_rdata;
    w_mem_req   = r_mem_req;
    w_mem_we    = r_mem_we;
    w_mem_addr  = r_mem_addr;
    w_mem_wdata = r_mem_wdata;
    w_mem_mask  = r_mem_mask;
    w_bus_err   = r_bus_err;
    unique case (r_state)
      S_IDLE: begin
        if (w_grant) begin
          w_own_d     = w_d_win;
          w_if_gnt    = w_if_win;
          w_d_gnt     = w_d_win;
          w_mem_we    = w_d_win && d_we;
          w_mem_addr  = w_d_win ? d_addr : if_addr;
          w_mem_wdata = w_d_win ? d_wdata : '0;
          w_mem_mask  = w_d_win ? d_mask : '1;
          if (w_d_win && if_req)
            w_starve = (r_starve == SMAX) ? SMAX : r_starve + 1'b1;
          else
            w_starve = '0;
        end
      end
      S_REQ: begin
        if (!r_mem_req) begin
          w_mem_req = 1'b1;
        end else if (mem_ack) begin
          w_mem_req = 1'b0;
          w_tcnt    = '0;
        end
      end
      S_WAIT: begin
        w_tcnt = r_tcnt + 1'b1;
        if (w_finish) begin
          if (r_own_d) begin
            w_d_done  = 1'b1;
            w_d_rdata = w_rd;
          end else begin
            w_if_rvalid = 1'b1;
            w_if_rdata  = w_rd;
          end
          if (!mem_done) w_bus_err = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_starve    <= '0;
      r_tcnt      <= '0;
      r_own_d     <= 1'b0;
      r_if_gnt    <= 1'b0;
      r_d_gnt     <= 1'b0;
      r_if_rvalid <= 1'b0;
      r_d_done    <= 1'b0;
      r_if_rdata  <= '0;
      r_d_rdata   <= '0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_mask  <= '0;
      r_bus_err   <= 1'b0;
    end else begin
      r_starve    <= w_starve;
      r_tcnt      <= w_tcnt;
      r_own_d     <= w_own_d;
      r_if_gnt    <= w_if_gnt;
      r_d_gnt     <= w_d_gnt;
      r_if_rvalid <= w_if_rvalid;
      r_d_done    <= w_d_done;
      r_if_rdata  <= w_if_rdata;
      r_d_rdata   <= w_d_rdata;
      r_mem_req   <= w_mem_req;
      r_mem_we    <= w_mem_we;
      r_mem_addr  <= w_mem_addr;
      r_mem_wdata <= w_mem_wdata;
      r_mem_mask  <= w_mem_mask;
      r_bus_err   <= w_bus_err;
    end
  end

  assign if_gnt    = r_if_gnt;
  assign d_gnt     = r_d_gnt;
  assign if_rvalid = r_if_rvalid;
  assign d_done    = r_d_done;
  assign if_rdata  = r_if_rdata;
  assign d_rdata   = r_d_rdata;
  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_mask  = r_mem_mask;
  assign bus_err   = r_bus_err;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed checks of arbitration, timing,
// masking, timeout, reset and halt behaviour.
module tb_mem_port_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        halted;
  logic        if_req;
  logic [15:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        d_req;
  logic        d_we;
  logic [15:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_mask;
  logic        d_gnt;
  logic        d_done;
  logic [31:0] d_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_mask;
  logic        mem_ack;
  logic        mem_done;
  logic [31:0] mem_rdata;
  logic        bus_err;

  int n_checks = 0;
  int n_errors = 0;

  mem_port_arbiter #(
    .N(32), .M(16), .STARVE_LIMIT(4), .TIMEOUT(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .halted(halted),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_mask(d_mask), .d_gnt(d_gnt),
    .d_done(d_done), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_mask(mem_mask),
    .mem_ack(mem_ack), .mem_done(mem_done),
    .mem_rdata(mem_rdata), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_gnt();
    int k;
    k = 0;
    do begin
      step();
      k++;
    end while (!if_gnt && !d_gnt && k < 20);
    if (!if_gnt && !d_gnt) check("gnt_timeout", 0, 1);
  endtask

  // Memory side: ack the request, wait lat cycles, then complete.
  task automatic serve(input logic [31:0] rd, input int lat);
    int k;
    k = 0;
    while (!mem_req && k < 10) begin
      step();
      k++;
    end
    if (!mem_req) check("serve_req_timeout", 0, 1);
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    repeat (lat) step();
    mem_done  = 1'b1;
    mem_rdata = rd;
    step();
    mem_done  = 1'b0;
    mem_rdata = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=%h exp=%h", 0, 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int n;
    rst_n = 1'b0; halted = 1'b0;
    if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0;
    d_wdata = '0; d_mask = '0;
    mem_ack = 1'b0; mem_done = 1'b0; mem_rdata = '0;
    #12;
    check("rst_ctl", {25'd0, if_gnt, d_gnt, if_rvalid, d_done,
                      mem_req, mem_we, bus_err}, 0);
    check("rst_addr", {16'd0, mem_addr}, 0);
    check("rst_mask", mem_mask, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // fetch timing
    if_req = 1'b1; if_addr = 16'h0010;
    step();
    check("t1_if_gnt", if_gnt, 1);
    check("t1_req_lat", mem_req, 0);
    if_req = 1'b0;
    step();
    check("t1_mem_req", mem_req, 1);
    check("t1_addr", {16'd0, mem_addr}, 32'h10);
    check("t1_mask", mem_mask, 32'hFFFF_FFFF);
    check("t1_we", mem_we, 0);
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    check("t1_req_drop", mem_req, 0);
    step();
    mem_done = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    step();
    mem_done = 1'b0; mem_rdata = '0;
    check("t1_rvalid", if_rvalid, 1);
    check("t1_rdata", if_rdata, 32'hDEAD_BEEF);
    step();
    check("t1_rvalid_pulse", if_rvalid, 0);

    // D priority, IF right after
    if_req = 1'b1; d_req = 1'b1; d_we = 1'b0;
    d_addr = 16'h0020; d_mask = 32'hFFFF_FFFF;
    step();
    check("t2_d_gnt", d_gnt, 1);
    check("t2_no_if_gnt", if_gnt, 0);
    d_req = 1'b0;
    serve(32'h1111_1111, 0);
    check("t2_d_done", d_done, 1);
    check("t2_d_rdata", d_rdata, 32'h1111_1111);
    step();
    check("t2_if_gnt_next", if_gnt, 1);
    if_req = 1'b0;
    serve(32'h2222_2222, 0);
    check("t2_if_rvalid", if_rvalid, 1);
    check("t2_if_rdata", if_rdata, 32'h2222_2222);

    // starvation guard: D,D,D,D,IF,D,D,D,D,IF
    d_req = 1'b1; if_req = 1'b1; d_we = 1'b0;
    for (int g = 0; g < 10; g++) begin
      wait_gnt();
      check($sformatf("t3_gnt%0d_is_if", g), {31'd0, if_gnt},
            (g == 4 || g == 9) ? 32'd1 : 32'd0);
      serve(32'h0, 0);
    end
    d_req = 1'b0; if_req = 1'b0;

    // masked load
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0104;
    d_mask = 32'h0000_00FF;
    wait_gnt();
    check("t4_d_gnt", d_gnt, 1);
    d_req = 1'b0;
    serve(32'h1234_5678, 1);
    check("t4_done", d_done, 1);
    check("t4_rdata", d_rdata, 32'h0000_0078);

    // timeout
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0300;
    d_mask = 32'hFFFF_FFFF;
    wait_gnt();
    d_req = 1'b0;
    step();
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    check("t5_err_before", bus_err, 0);
    k = 0;
    do begin
      step();
      k++;
    end while (!d_done && k < 20);
    check("t5_latency", k, 8);
    check("t5_rdata", d_rdata, 0);
    check("t5_bus_err", bus_err, 1);
    mem_done = 1'b1; mem_rdata = 32'h5555_5555;
    step();
    mem_done = 1'b0; mem_rdata = '0;
    check("t5_late_done", {30'd0, d_done, if_rvalid}, 0);
    check("t5_err_sticky", bus_err, 1);
    if_req = 1'b1; if_addr = 16'h0044;
    wait_gnt();
    check("t5_if_gnt", if_gnt, 1);
    if_req = 1'b0;
    serve(32'hA5A5_A5A5, 3);
    check("t5_if_rvalid", if_rvalid, 1);
    check("t5_if_rdata", if_rdata, 32'hA5A5_A5A5);
    check("t5_err_held", bus_err, 1);

    // store
    d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0200;
    d_wdata = 32'hCAFE_F00D; d_mask = 32'h0000_FFFF;
    wait_gnt();
    d_req = 1'b0;
    step();
    check("t4s_mem_req", mem_req, 1);
    check("t4s_we", mem_we, 1);
    check("t4s_wdata", mem_wdata, 32'hCAFE_F00D);
    check("t4s_mask", mem_mask, 32'h0000_FFFF);
    check("t4s_addr", {16'd0, mem_addr}, 32'h200);
    serve(32'hFFFF_FFFF, 0);
    check("t4s_done", d_done, 1);
    check("t4s_rdata", d_rdata, 0);

    // reset during WAIT
    d_req = 1'b1; d_we = 1'b0;
    wait_gnt();
    d_req = 1'b0;
    step();
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    step();
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_ctl", {28'd0, mem_req, bus_err, d_done, d_gnt}, 0);
    check("t6_rst_addr", {16'd0, mem_addr}, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    mem_done = 1'b1;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      mem_done = 1'b0;
      if (d_done || if_rvalid) n++;
    end
    check("t6_no_done", n, 0);
    check("t6_err_clear", bus_err, 0);

    // halt: in-flight access completes, then no grants
    d_req = 1'b1; d_we = 1'b0; d_mask = 32'hFFFF_FFFF;
    wait_gnt();
    check("t7_d_gnt", d_gnt, 1);
    halted = 1'b1;
    serve(32'h0F0F_0F0F, 0);
    check("t7_done", d_done, 1);
    check("t7_rdata", d_rdata, 32'h0F0F_0F0F);
    n = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (d_gnt || if_gnt) n++;
    end
    check("t7_no_gnt", n, 0);
    halted = 1'b0;
    wait_gnt();
    check("t7_gnt_resume", d_gnt, 1);
    d_req = 1'b0;
    serve(32'h0, 0);
    check("t7_done2", d_done, 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
